// File: rtl/mem_branch_unit_pkg.sv
// Shared encodings for the memory-conditional branch unit.
package mem_branch_unit_pkg;

   // Branch condition applied to the loaded word
   typedef enum logic [1:0] {
      BrBmz   = 2'b00,  // mem == 0
      BrBmnz  = 2'b01,  // mem != 0
      BrBmltz = 2'b10,  // mem < 0, signed
      BrBmgez = 2'b11   // mem >= 0, signed
   } br_mode_e;

   // Sequencer states
   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StReq     = 2'b01,
      StWait    = 2'b10,
      StResolve = 2'b11
   } state_e;

endpackage

// File: rtl/mem_branch_cond.sv
// Combinational branch condition: decides taken from the loaded word and mode.
module mem_branch_cond
   import mem_branch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] word,
   input  br_mode_e         mode,
   output logic             taken
);

   // Signed tests only need the sign bit
   always_comb begin
      taken = 1'b0;
      unique case (mode)
         BrBmz:   taken = (word == '0);
         BrBmnz:  taken = (word != '0);
         BrBmltz: taken = word[WIDTH-1];
         BrBmgez: taken = ~word[WIDTH-1];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_branch_unit.sv
// Memory-conditional branch unit: loads one word, tests it, and picks the next PC.
module mem_branch_unit
   import mem_branch_unit_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] base,
   input  logic [15:0]      offset,
   input  logic [WIDTH-1:0] pc_plus4,
   input  logic [WIDTH-1:0] target,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy,
   output logic             done,
   output logic             taken,
   output logic [WIDTH-1:0] next_pc,
   output logic             error
);

   localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_e           state_q, state_d;
   br_mode_e         mode_q, mode_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] pc4_q, pc4_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             taken_q, taken_d;
   logic             error_q, error_d;
   logic [WIDTH-1:0] next_pc_q, next_pc_d;

   logic [WIDTH-1:0] eff_addr;
   logic             cond_taken;

   // Effective address wraps modulo 2^WIDTH
   assign eff_addr = base + {{(WIDTH - 16){offset[15]}}, offset};

   // Condition is evaluated on the word in the cycle it is accepted
   mem_branch_cond #(
      .WIDTH (WIDTH)
   ) u_cond (
      .word  (mem_rdata),
      .mode  (mode_q),
      .taken (cond_taken)
   );

   // Next-state logic; results are latched on entry to resolve so they hold until the next done
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      addr_d    = addr_q;
      target_d  = target_q;
      pc4_d     = pc4_q;
      cnt_d     = cnt_q;
      taken_d   = taken_q;
      error_d   = error_q;
      next_pc_d = next_pc_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d   = br_mode_e'(mode);
               addr_d   = eff_addr;
               target_d = target;
               pc4_d    = pc_plus4;
               cnt_d    = '0;
               if (eff_addr[1:0] != 2'b00) begin
                  state_d   = StResolve;
                  taken_d   = 1'b0;
                  error_d   = 1'b1;
                  next_pc_d = pc_plus4;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq, StWait: begin
            if (mem_ready) begin
               state_d   = StResolve;
               taken_d   = cond_taken;
               error_d   = 1'b0;
               next_pc_d = cond_taken ? target_q : pc4_q;
            end else if (cnt_q == CntW'(TIMEOUT)) begin
               state_d   = StResolve;
               taken_d   = 1'b0;
               error_d   = 1'b1;
               next_pc_d = pc4_q;
            end else begin
               state_d = StWait;
               cnt_d   = cnt_q + CntW'(1);
            end
         end
         StResolve: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         mode_q    <= BrBmz;
         addr_q    <= '0;
         target_q  <= '0;
         pc4_q     <= '0;
         cnt_q     <= '0;
         taken_q   <= 1'b0;
         error_q   <= 1'b0;
         next_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         addr_q    <= addr_d;
         target_q  <= target_d;
         pc4_q     <= pc4_d;
         cnt_q     <= cnt_d;
         taken_q   <= taken_d;
         error_q   <= error_d;
         next_pc_q <= next_pc_d;
      end
   end

   assign mem_req  = (state_q == StReq) || (state_q == StWait);
   assign mem_addr = addr_q;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StResolve);
   assign taken    = taken_q;
   assign next_pc  = next_pc_q;
   assign error    = error_q;

endmodule

// File: tb/tb_mem_branch_unit.sv
// Bench for mem_branch_unit: timeline model checked every cycle plus directed literal checks.
module tb_mem_branch_unit;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [31:0] base = '0;
   logic [15:0] offset = '0;
   logic [31:0] pc_plus4 = '0;
   logic [31:0] target = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        busy, done, taken, error;
   logic [31:0] next_pc;

   int errors = 0;
   int checks = 0;

   mem_branch_unit #(
      .WIDTH   (32),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .base      (base),
      .offset    (offset),
      .pc_plus4  (pc_plus4),
      .target    (target),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .taken     (taken),
      .next_pc   (next_pc),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_of(input logic [1:0] md, input logic [31:0] w);
      case (md)
         2'd0:    return w == 0;
         2'd1:    return w != 0;
         2'd2:    return $signed(w) < 0;
         default: return $signed(w) >= 0;
      endcase
   endfunction

   // Timeline model: one operation in flight, done cycle fixed once its outcome is known
   int          cyc = 0;
   bit          m_valid = 0, m_fly = 0, m_known = 0;
   int          m_issue, m_done_cyc;
   logic [1:0]  m_mode;
   logic [31:0] m_addr, m_tgt, m_pc4;
   bit          r_taken, r_err;
   logic [31:0] r_npc;
   bit          exp_busy, exp_req, exp_done, exp_taken, exp_err;
   logic [31:0] exp_npc, exp_addr;

   always @(posedge clk) begin
      if (reset) begin
         m_valid   = 1;
         m_fly     = 0;
         exp_taken = 0;
         exp_err   = 0;
         exp_npc   = 0;
      end else if (!m_fly) begin
         if (start) begin
            m_fly   = 1;
            m_issue = cyc;
            m_mode  = mode;
            m_tgt   = target;
            m_pc4   = pc_plus4;
            m_addr  = base + {{16{offset[15]}}, offset};
            if (m_addr % 4 != 0) begin
               m_known    = 1;
               m_done_cyc = cyc + 1;
               r_taken    = 0;
               r_err      = 1;
               r_npc      = m_pc4;
            end else begin
               m_known = 0;
            end
         end
      end else if (!m_known) begin
         if (mem_ready) begin
            m_known    = 1;
            m_done_cyc = cyc + 1;
            r_taken    = cond_of(m_mode, mem_rdata);
            r_err      = 0;
            r_npc      = r_taken ? m_tgt : m_pc4;
         end else if (cyc - m_issue == TO + 1) begin
            m_known    = 1;
            m_done_cyc = cyc + 1;
            r_taken    = 0;
            r_err      = 1;
            r_npc      = m_pc4;
         end
      end else if (cyc == m_done_cyc) begin
         m_fly = 0;
      end
      exp_busy = m_fly;
      exp_req  = m_fly && !m_known;
      exp_done = m_fly && m_known && (m_done_cyc == cyc + 1);
      exp_addr = m_addr;
      if (exp_done) begin
         exp_taken = r_taken;
         exp_err   = r_err;
         exp_npc   = r_npc;
      end
      cyc++;
   end

   // Compare every cycle, mid-cycle
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", busy, exp_busy);
         chk("mem_req", mem_req, exp_req);
         chk("done", done, exp_done);
         chk("taken", taken, exp_taken);
         chk("error", error, exp_err);
         chk("next_pc", next_pc, exp_npc);
         if (exp_req) chk("mem_addr", mem_addr, exp_addr);
      end
   end

   // One operation; ra = request cycles without ready before ready (-1 never)
   task automatic run_op(input logic [1:0] md, input logic [31:0] b, input logic [15:0] off,
                         input logic [31:0] pc4, input logic [31:0] tg, input int ra,
                         input logic [31:0] rd, input bit hold, input logic [31:0] eaddr,
                         output int lat, output bit tk, output bit er,
                         output logic [31:0] npc, output bit saw_req, output bit addr_ok);
      @(negedge clk);
      #1;
      start    = 1'b1;
      mode     = md;
      base     = b;
      offset   = off;
      pc_plus4 = pc4;
      target   = tg;
      lat      = 0;
      tk       = 0;
      er       = 0;
      npc      = '0;
      saw_req  = 0;
      addr_ok  = 1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (mem_req) begin
            saw_req = 1;
            if (mem_addr !== eaddr) addr_ok = 0;
         end
         if (done) begin
            lat = k;
            tk  = taken;
            er  = error;
            npc = next_pc;
         end
         #1;
         if (!hold) start = 1'b0;
         mem_ready = (lat == 0) && (ra >= 0) && (k - 1 == ra);
         mem_rdata = rd;
      end
      mem_ready = 1'b0;
      if (hold) begin
         @(negedge clk);
         chk("start_in_done_ignored", busy, 0);
         #1;
      end
      start = 1'b0;
   endtask

   int          lat;
   bit          tk, er, sr, aok;
   logic [31:0] npc;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_npc", next_pc, 0);
      #1 reset = 1'b0;

      // BMZ hit, zero-wait
      run_op(2'd0, 32'd4, 16'd4, 32'h1C, 32'h40, 0, 32'd0, 0, 32'd8, lat, tk, er, npc, sr, aok);
      chk("t1_lat", lat, 2);
      chk("t1_taken", tk, 1);
      chk("t1_npc", npc, 32'h40);
      chk("t1_addr", aok, 1);

      // BMZ miss after 3 wait cycles, address 12
      run_op(2'd0, 32'd8, 16'd4, 32'h20, 32'h80, 3, 32'd24, 0, 32'd12, lat, tk, er, npc, sr, aok);
      chk("t2_lat", lat, 5);
      chk("t2_taken", tk, 0);
      chk("t2_npc", npc, 32'h20);
      chk("t2_addr", aok, 1);

      run_op(2'd2, 32'h100, 16'd0, 32'h24, 32'h90, 0, 32'hFFFF_FFFF, 0, 32'h100,
             lat, tk, er, npc, sr, aok);
      chk("bmltz_taken", tk, 1);
      run_op(2'd3, 32'h100, 16'd0, 32'h24, 32'h90, 1, 32'hFFFF_FFFF, 0, 32'h100,
             lat, tk, er, npc, sr, aok);
      chk("bmgez_taken", tk, 0);
      chk("bmgez_npc", npc, 32'h24);
      run_op(2'd1, 32'h100, 16'd0, 32'h24, 32'h90, 0, 32'h1, 0, 32'h100,
             lat, tk, er, npc, sr, aok);
      chk("bmnz_taken", tk, 1);

      // Misaligned
      run_op(2'd0, 32'd5, 16'd0, 32'h30, 32'h50, 0, 32'd0, 0, 32'd5, lat, tk, er, npc, sr, aok);
      chk("mis_lat", lat, 1);
      chk("mis_err", er, 1);
      chk("mis_taken", tk, 0);
      chk("mis_noreq", sr, 0);

      // Timeout
      run_op(2'd0, 32'd16, 16'd0, 32'h34, 32'h60, -1, 32'd0, 0, 32'd16,
             lat, tk, er, npc, sr, aok);
      chk("to_lat", lat, 17);
      chk("to_err", er, 1);
      chk("to_taken", tk, 0);

      // Negative offset, start held high through done
      run_op(2'd3, 32'h100, 16'hFFF0, 32'h38, 32'h70, 2, 32'd5, 1, 32'hF0,
             lat, tk, er, npc, sr, aok);
      chk("neg_addr", aok, 1);
      chk("neg_lat", lat, 4);
      chk("neg_npc", npc, 32'h70);

      // Ready while idle is ignored
      @(negedge clk);
      #1 mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ready_busy", busy, 0);
      chk("idle_ready_done", done, 0);
      #1 mem_ready = 1'b0;

      // Reset in WAIT, then a late ready
      @(negedge clk);
      #1;
      start  = 1'b1;
      mode   = 2'd0;
      base   = 32'd0;
      offset = 16'h10;
      repeat (3) begin
         @(negedge clk);
         #1 start = 1'b0;
      end
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      reset     = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_req", mem_req, 0);
      chk("rst_mid_taken", taken, 0);
      chk("rst_mid_err", error, 0);
      chk("rst_mid_npc", next_pc, 0);
      #1 mem_ready = 1'b0;

      // Address wrap-around
      run_op(2'd0, 32'hFFFF_FFFC, 16'd8, 32'h44, 32'hA0, 0, 32'd0, 0, 32'd4,
             lat, tk, er, npc, sr, aok);
      chk("wrap_req", sr, 1);
      chk("wrap_addr", aok, 1);
      chk("wrap_lat", lat, 2);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_branch_unit.md
MEM_BRANCH_UNIT -- requirements
Module: mem_branch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word and address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of wait cycles for a memory response before the operation aborts.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: issue a memory-conditional branch; sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 BMZ (mem==0), 01 BMNZ (mem!=0), 10 BMLTZ (mem<0, signed), 11 BMGEZ (mem>=0, signed).
REQ-007 The block SHALL have port base, input, WIDTH bits: the rs register value.
REQ-008 The block SHALL have port offset, input, 16 bits: the immediate, sign-extended to WIDTH.
REQ-009 The block SHALL have port pc_plus4, input, WIDTH bits: the fall-through PC.
REQ-010 The block SHALL have port target, input, WIDTH bits: the branch target PC.
REQ-011 The block SHALL have port mem_req, output, 1 bit: word read request to data memory.
REQ-012 The block SHALL have port mem_addr, output, WIDTH bits: the byte address of the word read.
REQ-013 The block SHALL have port mem_ready, input, 1 bit: mem_rdata is valid this cycle.
REQ-014 The block SHALL have port mem_rdata, input, WIDTH bits: the little-endian word read from memory.
REQ-015 The block SHALL have port busy, output, 1 bit: the block is not in IDLE; the fetch stage stalls while it is high.
REQ-016 The block SHALL have port done, output, 1 bit: a one-cycle pulse signalling that the result is valid.
REQ-017 The block SHALL have port taken, output, 1 bit: the condition held; valid with done.
REQ-018 The block SHALL have port next_pc, output, WIDTH bits: target if taken, else pc_plus4; valid with done.
REQ-019 The block SHALL have port error, output, 1 bit: misalignment or timeout; valid with done.

Function
REQ-020 The block SHALL have FSM states IDLE, REQ, WAIT and RESOLVE.
REQ-021 In IDLE, start=1 SHALL capture mode, target, pc_plus4 and addr = base + sext(offset) (modulo 2^WIDTH, wrap-around permitted), then move to REQ.
REQ-022 The block SHALL treat addr[1:0]!=0 as misaligned: it SHALL go from IDLE directly to RESOLVE with error=1, taken=0 and no mem_req.
REQ-023 In REQ and WAIT, mem_req SHALL be 1 and mem_addr SHALL equal the captured addr; mem_req SHALL be 0 in all other states.
REQ-024 If mem_ready=1 in REQ or WAIT, the block SHALL capture mem_rdata and go to RESOLVE; otherwise REQ SHALL go to WAIT and WAIT SHALL stay in WAIT.
REQ-025 A wait counter SHALL clear on entry to REQ and increment on each cycle spent in REQ or WAIT without mem_ready.
REQ-026 When the wait counter reaches TIMEOUT, the block SHALL go to RESOLVE with error=1 and taken=0.
REQ-027 In RESOLVE, done SHALL be 1 for exactly one cycle, and the state SHALL then return to IDLE.
REQ-028 taken SHALL be evaluated on the captured word according to mode; next_pc SHALL equal taken ? target : pc_plus4.
REQ-029 taken, next_pc and error SHALL hold their values until the next done.
REQ-030 Minimum latency SHALL be 2 cycles from start to done, with zero-wait memory.
REQ-031 start while busy SHALL be ignored; start in the same cycle as done SHALL also be ignored.
REQ-032 mem_ready outside REQ or WAIT SHALL be ignored.
REQ-033 busy SHALL be 1 in REQ, WAIT and RESOLVE.

Reset
REQ-034 reset SHALL be synchronous and active-high, and SHALL have priority over start.
REQ-035 On reset, state SHALL be IDLE, and mem_req, busy, done, taken and error SHALL be 0, next_pc SHALL be 0 and the wait counter SHALL be 0.
REQ-036 Reset asserted mid-operation (REQ or WAIT) SHALL abort the operation with no done pulse; a late mem_ready SHALL then be ignored.

Structure
REQ-037 The mode encodings (BMZ, BMNZ, BMLTZ, BMGEZ) and the FSM state encodings SHALL live in the shared constants include file next to the register and opcode defines.
REQ-038 The condition evaluation SHALL be one combinational sub-module, mem_branch_cond (word, mode -> taken).

Verification
REQ-039 BMZ, base=4, offset=4, word at byte 8 = 0, mem_ready same cycle, target=0x40, pc_plus4=0x1C -> done on cycle 2, taken=1, next_pc=0x40.
REQ-040 BMZ, word at byte 12 = 24, mem_ready after 3 wait cycles -> taken=0, next_pc=pc_plus4, done on cycle 5, mem_addr=12 throughout REQ and WAIT.
REQ-041 BMLTZ with word 0xFFFFFFFF -> taken=1; BMGEZ with the same word -> taken=0; BMNZ with 0x00000001 -> taken=1.
REQ-042 base=5, offset=0 (misaligned) -> mem_req never asserted, done 1 cycle after start, error=1, taken=0.
REQ-043 mem_ready never asserted, TIMEOUT=15 -> done with error=1 exactly 17 cycles after start.
REQ-044 Reset during WAIT, then mem_ready=1 -> no done, state IDLE, all outputs 0; a new start with base=0xFFFFFFFC, offset=8 -> mem_addr=4 (wrap-around).
